axi_master: RTL and testbench
=============================

AXI_MASTER -- requirements
Module: axi_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data bus width (only 32 is required).
REQ-002 SHALL have parameter C_TARGET_ADDR, default 32'h0000_0000, base address of the test region.
REQ-003 SHALL have parameter C_BURST_LEN, default 16, beats per burst.
REQ-004 SHALL have parameter C_NUM_BURSTS, default 4, bursts per pass.
REQ-005 SHALL use one clock, ACLK (input, 1 bit); all logic on the rising edge.
REQ-006 SHALL use reset ARESETN (input, 1 bit); reset is synchronous and active-low.
REQ-007 SHALL have AW outputs: M_AXI_AWID 1, AWADDR 32, AWLEN 8, AWSIZE 3, AWBURST 2, AWLOCK 2, AWCACHE 4, AWPROT 3, AWQOS 4, AWUSER 1, AWVALID 1; input M_AXI_AWREADY 1.
REQ-008 SHALL have W outputs: M_AXI_WDATA 32, WSTRB 4, WLAST 1, WUSER 1, WVALID 1; input M_AXI_WREADY 1.
REQ-009 SHALL have B inputs: M_AXI_BID 1, BRESP 2, BUSER 1, BVALID 1; output M_AXI_BREADY 1.
REQ-010 SHALL have AR outputs with the same set and widths as AW (M_AXI_AR*); input M_AXI_ARREADY 1.
REQ-011 SHALL have R inputs: M_AXI_RID 1, RDATA 32, RRESP 2, RLAST 1, RUSER 1, RVALID 1; output M_AXI_RREADY 1.
REQ-012 SHALL have output ERROR, 1 bit, sticky test-failure flag.

Function
REQ-013 SHALL drive these constants: ID=0, LEN=C_BURST_LEN-1 (8'h0F), SIZE=3'b010, BURST=2'b01 (INCR), LOCK=0, CACHE=4'b0011, PROT=0, QOS=0, USER=0, WSTRB=4'hF.
REQ-014 SHALL implement states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-015 SHALL move IDLE->WR_ADDR one cycle after reset release.
REQ-016 SHALL, for burst i, present address C_TARGET_ADDR + i*C_BURST_LEN*4 (0x00, 0x40, 0x80, 0xC0).
REQ-017 SHALL assert AxVALID in WR_ADDR/RD_ADDR, hold it and the address stable until AxREADY, deassert in the cycle after the handshake.
REQ-018 SHALL start W beats only after the AW handshake (WR_DATA); WVALID held with data stable until WREADY.
REQ-019 SHALL make beat k (0..15) of write burst i carry WDATA = i*16+k+1 (values 1..64 over a pass).
REQ-020 SHALL assert WLAST only on beat C_BURST_LEN-1.
REQ-021 SHALL assert BREADY only in WR_RESP; on the B handshake go to WR_ADDR for the next burst, or to RD_ADDR after burst C_NUM_BURSTS-1.
REQ-022 SHALL assert RREADY only in RD_DATA; each accepted beat is compared against the same pattern as REQ-019.
REQ-023 SHALL leave RD_DATA on the accepted RLAST beat, going to RD_ADDR for the next burst, or DONE after the last burst.
REQ-024 SHALL hold DONE with all VALID/READY low until reset.
REQ-025 SHALL set ERROR one cycle after any of: RDATA mismatch; RRESP≠0; BRESP≠0; RLAST low on beat 15; RLAST high on an earlier beat.
REQ-026 SHALL keep ERROR set (sticky) until reset.
REQ-027 SHALL not combinationally depend any VALID on any READY input.
REQ-028 SHALL tolerate READY asserted in the same cycle as VALID (single-cycle handshake).

Reset
REQ-029 SHALL, while ARESETN=0 at a clock edge: state=IDLE, burst/beat counters=0, all VALIDs=0, BREADY=RREADY=0, WLAST=0, ERROR=0.
REQ-030 SHALL, on reset mid-transfer, abandon the transfer and restart the full sequence from burst 0 after release.

Structure
REQ-031 SHALL place the state enum and AXI encodings (BURST_INCR, SIZE_4B, RESP_OKAY) in shared package axi_master_pkg.
REQ-032 SHALL be a single module with no sub-module; target 150-300 RTL lines.

Verification (with axi_slave_bfm, AWREADY/ARREADY not usually high)
REQ-033 SHALL verify reset: ARESETN low 10 cycles -> AWVALID=WVALID=ARVALID=BREADY=RREADY=ERROR=0.
REQ-034 SHALL verify the first write: AWADDR=0x0, AWLEN=0x0F, AWSIZE=2, AWBURST=1; WDATA 1..16; WLAST only with 16.
REQ-035 SHALL verify backpressure: AWREADY delayed 3 cycles -> AWVALID/AWADDR unchanged until handshake; WREADY toggling -> no beat lost or duplicated.
REQ-036 SHALL verify the full pass: ARADDR 0x00, 0x40, 0x80, 0xC0; RDATA 1..64 returned -> DONE reached within 1000 cycles, ERROR=0.
REQ-037 SHALL verify a data error: slave corrupts read beat 5 of burst 0 -> ERROR=1 the next cycle and still 1 at DONE.
REQ-038 SHALL verify a response error: BRESP=2'b10 on burst 1 -> ERROR=1; reset during RD_DATA -> restart at AWADDR=0x0 with ERROR=0.

Source files
------------

// File: rtl/axi_master_pkg.sv
// Shared state encoding and AXI field constants for the burst test master.
package axi_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B       = 3'b010;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;

  // Beat k of burst b carries b*burst_len + k + 1, so a pass never writes zero.
  function automatic logic [31:0] beat_pattern(input logic [7:0]  burst,
                                               input logic [7:0]  beat,
                                               input logic [31:0] burst_len);
    return 32'(burst) * burst_len + 32'(beat) + 32'd1;
  endfunction

endpackage

// File: rtl/axi_master.sv
// AXI4 burst test master: writes an incrementing pattern over C_NUM_BURSTS bursts,
// reads it back, and raises a sticky ERROR on any data, response or RLAST fault.
module axi_master
  import axi_master_pkg::*;
#(
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_TARGET_ADDR      = 32'h0000_0000,
  parameter int          C_BURST_LEN        = 16,
  parameter int          C_NUM_BURSTS       = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  // write address
  output logic [0:0]                        M_AXI_AWID,
  output logic [31:0]                       M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic [2:0]                        M_AXI_AWSIZE,
  output logic [1:0]                        M_AXI_AWBURST,
  output logic [1:0]                        M_AXI_AWLOCK,
  output logic [3:0]                        M_AXI_AWCACHE,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic [3:0]                        M_AXI_AWQOS,
  output logic [0:0]                        M_AXI_AWUSER,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic [0:0]                        M_AXI_WUSER,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // write response
  input  logic [0:0]                        M_AXI_BID,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic [0:0]                        M_AXI_BUSER,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // read address
  output logic [0:0]                        M_AXI_ARID,
  output logic [31:0]                       M_AXI_ARADDR,
  output logic [7:0]                        M_AXI_ARLEN,
  output logic [2:0]                        M_AXI_ARSIZE,
  output logic [1:0]                        M_AXI_ARBURST,
  output logic [1:0]                        M_AXI_ARLOCK,
  output logic [3:0]                        M_AXI_ARCACHE,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic [3:0]                        M_AXI_ARQOS,
  output logic [0:0]                        M_AXI_ARUSER,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // read data
  input  logic [0:0]                        M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RLAST,
  input  logic [0:0]                        M_AXI_RUSER,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  output logic                              ERROR
);

  localparam logic [7:0] LAST_BEAT  = 8'(C_BURST_LEN - 1);
  localparam logic [7:0] LAST_BURST = 8'(C_NUM_BURSTS - 1);

  state_e      state_q, state_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  beat_q,  beat_d;
  logic        error_q, error_d;

  logic [31:0] burst_addr;
  logic [31:0] beat_data;
  logic        rd_bad;
  logic        unused_inputs;

  // IDs and user sidebands are fixed at zero, so nothing returned on them matters.
  assign unused_inputs = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_RID, M_AXI_RUSER};

  assign burst_addr = C_TARGET_ADDR + 32'(burst_q) * 32'(C_BURST_LEN * 4);
  assign beat_data  = beat_pattern(burst_q, beat_q, 32'(C_BURST_LEN));

  assign rd_bad = (M_AXI_RDATA != C_M_AXI_DATA_WIDTH'(beat_data))
               || (M_AXI_RRESP != RESP_OKAY)
               || (M_AXI_RLAST != (beat_q == LAST_BEAT));

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      burst_q <= '0;
      beat_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        state_d = WR_ADDR;
        burst_d = '0;
        beat_d  = '0;
      end
      WR_ADDR: begin
        if (M_AXI_AWREADY) begin
          state_d = WR_DATA;
          beat_d  = '0;
        end
      end
      WR_DATA: begin
        if (M_AXI_WREADY) begin
          if (beat_q == LAST_BEAT) begin
            state_d = WR_RESP;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) error_d = 1'b1;
          if (burst_q == LAST_BURST) begin
            state_d = RD_ADDR;
            burst_d = '0;
          end else begin
            state_d = WR_ADDR;
            burst_d = burst_q + 8'd1;
          end
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = RD_DATA;
          beat_d  = '0;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          if (rd_bad) error_d = 1'b1;
          // The slave's RLAST ends the burst even when it arrives on the wrong beat.
          if (M_AXI_RLAST) begin
            beat_d = '0;
            if (burst_q == LAST_BURST) begin
              state_d = DONE;
            end else begin
              state_d = RD_ADDR;
              burst_d = burst_q + 8'd1;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Every VALID/READY is decoded from registered state only.
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = burst_addr;
  assign M_AXI_AWLEN   = LAST_BEAT;
  assign M_AXI_AWSIZE  = SIZE_4B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = '0;
  assign M_AXI_AWCACHE = CACHE_BUF_MOD;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_AWVALID = (state_q == WR_ADDR);

  assign M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(beat_data);
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = (state_q == WR_DATA) && (beat_q == LAST_BEAT);
  assign M_AXI_WUSER   = '0;
  assign M_AXI_WVALID  = (state_q == WR_DATA);

  assign M_AXI_BREADY  = (state_q == WR_RESP);

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = burst_addr;
  assign M_AXI_ARLEN   = LAST_BEAT;
  assign M_AXI_ARSIZE  = SIZE_4B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = '0;
  assign M_AXI_ARCACHE = CACHE_BUF_MOD;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = (state_q == RD_ADDR);

  assign M_AXI_RREADY  = (state_q == RD_DATA);

  assign ERROR         = error_q;

endmodule

// File: tb/tb_axi_master.sv
// Bench for axi_master: behavioural memory slave with configurable backpressure
// and fault injection, plus a scoreboard of expected AW/W/AR transfers.
module tb_axi_master;

  logic        ACLK    = 1'b0;
  logic        ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [0:0]  AWID, AWUSER, WUSER, ARID, ARUSER;
  logic [31:0] AWADDR, ARADDR, WDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, AWPROT, ARSIZE, ARPROT;
  logic [1:0]  AWBURST, AWLOCK, ARBURST, ARLOCK;
  logic [3:0]  AWCACHE, AWQOS, ARCACHE, ARQOS, WSTRB;
  logic        AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, ERROR;

  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0;
  logic        RVALID = 1'b0, RLAST = 1'b0;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0] RDATA = 32'h0;
  logic [0:0]  BID = 1'b0, BUSER = 1'b0, RID = 1'b0, RUSER = 1'b0;

  axi_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE),
    .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS), .M_AXI_AWUSER(AWUSER),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WUSER(WUSER),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BUSER(BUSER), .M_AXI_BVALID(BVALID),
    .M_AXI_BREADY(BREADY),
    .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
    .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK), .M_AXI_ARCACHE(ARCACHE),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARQOS(ARQOS), .M_AXI_ARUSER(ARUSER),
    .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
    .M_AXI_RUSER(RUSER), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
    .ERROR(ERROR)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave configuration, changed between directed steps
  int aw_delay = 0, ar_delay = 0;
  bit wready_toggle = 1'b0;
  int bresp_err_burst = -1;
  int corrupt_burst = -1, corrupt_beat = -1;

  logic [31:0] exp_aw[$];
  logic [31:0] exp_ar[$];
  logic [32:0] exp_w[$];

  logic [31:0] mem [0:63];

  int aw_wait = 0, ar_wait = 0;
  int wr_ptr = 0, w_beat = 0, wr_burst = 0;
  int rd_ptr = 0, rd_beat = 0, rd_burst = 0, rd_beats_seen = 0;
  bit aw_hs = 0, w_hs = 0, w_last_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  bit wphase = 0, bphase = 0, rphase = 0;
  bit err_model = 0, err_pending = 0;
  bit aw_hold_chk = 0, w_hold_chk = 0, ar_hold_chk = 0;
  bit aw_done_prev = 0, ar_done_prev = 0;
  logic [31:0] aw_hold = 0, w_hold = 0, ar_hold = 0;

  // Monitor / scoreboard: observes the values that the next rising edge will sample.
  always @(negedge ACLK) begin
    logic [31:0] ea;
    logic [32:0] ew;
    check("error_flag", 64'(ERROR), 64'(err_model));
    check("wvalid_window", 64'(WVALID), 64'(wphase));
    check("bready_window", 64'(BREADY), 64'(bphase));
    check("rready_window", 64'(RREADY), 64'(rphase));
    if (aw_hold_chk) check("aw_held", 64'({AWVALID, AWADDR}), 64'({1'b1, aw_hold}));
    if (w_hold_chk)  check("w_held",  64'({WVALID, WDATA}),   64'({1'b1, w_hold}));
    if (ar_hold_chk) check("ar_held", 64'({ARVALID, ARADDR}), 64'({1'b1, ar_hold}));
    if (aw_done_prev) check("awvalid_drop", 64'(AWVALID), 64'(0));
    if (ar_done_prev) check("arvalid_drop", 64'(ARVALID), 64'(0));

    aw_hs = ARESETN && AWVALID && AWREADY;
    w_hs  = ARESETN && WVALID  && WREADY;
    b_hs  = ARESETN && BVALID  && BREADY;
    ar_hs = ARESETN && ARVALID && ARREADY;
    r_hs  = ARESETN && RVALID  && RREADY;
    w_last_hs = 1'b0;
    aw_hold_chk = ARESETN && AWVALID && !AWREADY;  aw_hold = AWADDR;
    w_hold_chk  = ARESETN && WVALID  && !WREADY;   w_hold  = WDATA;
    ar_hold_chk = ARESETN && ARVALID && !ARREADY;  ar_hold = ARADDR;
    aw_done_prev = aw_hs;
    ar_done_prev = ar_hs;

    if (aw_hs) begin
      ea = (exp_aw.size() > 0) ? exp_aw.pop_front() : 32'hDEAD_BEEF;
      check("awaddr", 64'(AWADDR), 64'(ea));
      check("aw_len_size_burst", 64'({AWLEN, AWSIZE, AWBURST}), 64'({8'h0F, 3'd2, 2'd1}));
      check("aw_attrs", 64'({AWID, AWLOCK, AWCACHE, AWPROT, AWQOS, AWUSER}),
            64'({1'b0, 2'b00, 4'b0011, 3'b000, 4'h0, 1'b0}));
      wr_ptr = int'(AWADDR[7:2]);
      w_beat = 0;
      wphase = 1'b1;
    end
    if (w_hs) begin
      ew = (exp_w.size() > 0) ? exp_w.pop_front() : 33'h1_DEAD_BEEF;
      check("wdata", 64'(WDATA), 64'(ew[31:0]));
      check("wlast", 64'(WLAST), 64'(ew[32]));
      check("wstrb", 64'(WSTRB), 64'(4'hF));
      mem[6'(wr_ptr)] = WDATA;
      wr_ptr++;
      if (w_beat == 15) begin
        w_beat = 0;
        wphase = 1'b0;
        bphase = 1'b1;
        w_last_hs = 1'b1;
      end else begin
        w_beat++;
      end
    end
    if (b_hs) begin
      if (BRESP != 2'b00) err_pending = 1'b1;
      bphase = 1'b0;
    end
    if (ar_hs) begin
      ea = (exp_ar.size() > 0) ? exp_ar.pop_front() : 32'hDEAD_BEEF;
      check("araddr", 64'(ARADDR), 64'(ea));
      check("ar_len_size_burst", 64'({ARLEN, ARSIZE, ARBURST}), 64'({8'h0F, 3'd2, 2'd1}));
      rd_ptr = int'(ARADDR[7:2]);
      rphase = 1'b1;
    end
    if (r_hs) begin
      if (RDATA !== 32'(rd_burst * 16 + rd_beat + 1) || RRESP != 2'b00
          || RLAST !== (rd_beat == 15))
        err_pending = 1'b1;
      rd_beats_seen++;
      if (rd_beat == 15) rphase = 1'b0;
    end
  end

  // Slave responder: updates its outputs just after each rising edge.
  always begin
    @(posedge ACLK);
    #1;
    if (!ARESETN) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
      RVALID = 0; RLAST = 0; RRESP = 0; RDATA = 0;
      aw_wait = 0; ar_wait = 0; w_beat = 0; wr_burst = 0;
      rd_beat = 0; rd_burst = 0; rd_beats_seen = 0;
      wphase = 0; bphase = 0; rphase = 0; err_model = 0; err_pending = 0;
    end else begin
      err_model = err_model | err_pending;
      err_pending = 1'b0;
      if (aw_hs) begin
        AWREADY = 0; aw_wait = 0;
      end else if (AWVALID && !AWREADY) begin
        if (aw_wait >= aw_delay) AWREADY = 1; else aw_wait++;
      end
      WREADY = wready_toggle ? !WREADY : 1'b1;
      if (b_hs) begin
        BVALID = 0; wr_burst++;
      end
      if (w_last_hs) begin
        BVALID = 1;
        BRESP  = (wr_burst == bresp_err_burst) ? 2'b10 : 2'b00;
      end
      if (ar_hs) begin
        ARREADY = 0; ar_wait = 0;
      end else if (ARVALID && !ARREADY) begin
        if (ar_wait >= ar_delay) ARREADY = 1; else ar_wait++;
      end
      if (ar_hs) begin
        RVALID = 1; rd_beat = 0;
      end else if (r_hs) begin
        if (rd_beat == 15) begin
          RVALID = 0; rd_beat = 0; rd_burst++;
        end else begin
          rd_beat++;
        end
      end
      RDATA = mem[6'(rd_ptr + rd_beat)]
            ^ ((rd_burst == corrupt_burst && rd_beat == corrupt_beat) ? 32'h0000_00FF : 32'h0);
      RLAST = RVALID && (rd_beat == 15);
    end
    aw_hs = 0; w_hs = 0; w_last_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
  end

  task automatic load_pass();
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    for (int i = 0; i < 4; i++) begin
      exp_aw.push_back(32'(i * 64));
      exp_ar.push_back(32'(i * 64));
      for (int k = 0; k < 16; k++) exp_w.push_back({(k == 15), 32'(i * 16 + k + 1)});
    end
  endtask

  task automatic wait_reads(input int target, input int budget, input string tag);
    int n = 0;
    while (rd_beats_seen < target && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    check(tag, 64'(rd_beats_seen >= target), 64'(1));
  endtask

  task automatic check_idle_bus(input string tag);
    check(tag, 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, WLAST}), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset held for 10 cycles
    repeat (10) @(posedge ACLK);
    @(negedge ACLK);
    check_idle_bus("reset_outputs");
    check("reset_error", 64'(ERROR), 64'(0));

    // Full pass with AWREADY delayed 3 cycles and toggling WREADY
    @(posedge ACLK); #2;
    aw_delay = 3; ar_delay = 2; wready_toggle = 1'b1;
    load_pass();
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("idle_after_release", 64'(AWVALID), 64'(0));
    @(negedge ACLK);
    check("wr_addr_entry", 64'({AWVALID, AWADDR}), 64'({1'b1, 32'h0}));
    wait_reads(64, 1000, "pass_done_in_time");
    repeat (5) @(negedge ACLK);
    check_idle_bus("done_quiet");
    check("pass_error", 64'(ERROR), 64'(0));
    check("pass_queues_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 64'(0));

    // Read data corruption on burst 0 beat 5, single-cycle handshakes
    @(posedge ACLK); #2;
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK); #2;
    aw_delay = 0; ar_delay = 0; wready_toggle = 1'b0;
    corrupt_burst = 0; corrupt_beat = 5;
    load_pass();
    ARESETN = 1'b1;
    wait_reads(64, 1000, "corrupt_pass_done");
    repeat (3) @(negedge ACLK);
    check("error_sticky_at_done", 64'(ERROR), 64'(1));
    check_idle_bus("corrupt_done_quiet");

    // BRESP error on burst 1, then reset during the read phase
    @(posedge ACLK); #2;
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK); #2;
    aw_delay = 1; ar_delay = 1; wready_toggle = 1'b1;
    corrupt_burst = -1; corrupt_beat = -1; bresp_err_burst = 1;
    load_pass();
    ARESETN = 1'b1;
    wait_reads(3, 1000, "reached_rd_data");
    check("bresp_error_flag", 64'(ERROR), 64'(1));
    @(posedge ACLK); #2;
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_clears_error", 64'(ERROR), 64'(0));
    check_idle_bus("midreset_outputs");
    @(posedge ACLK); #2;
    bresp_err_burst = -1;
    load_pass();
    ARESETN = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    check("restart_awaddr", 64'({AWVALID, AWADDR}), 64'({1'b1, 32'h0}));
    wait_reads(64, 1000, "restart_pass_done");
    repeat (3) @(negedge ACLK);
    check("restart_error", 64'(ERROR), 64'(0));
    check("restart_queues_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
